regfile_wb_buffer: RTL and testbench
====================================

REGFILE_WB_BUFFER -- requirements
Module: regfile_wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queued write-back entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, producer presents a write-back request.
REQ-005 SHALL have port in_ready, output, 1, buffer can accept a request this cycle.
REQ-006 SHALL have port in_reg, input, 5, destination register number.
REQ-007 SHALL have port in_data, input, 64, destination value.
REQ-008 SHALL have port wr_stall, input, 1, register-file write port unavailable this cycle.
REQ-009 SHALL have port RegWrite, output, 1, write strobe to the register file.
REQ-010 SHALL have port WriteRegister, output, 5, register-file write address.
REQ-011 SHALL have port WriteData, output, 64, register-file write data.
REQ-012 SHALL have ports ReadRegister1 and ReadRegister2, input, 5 each, read addresses snooped from the register file.
REQ-013 SHALL have ports fwd_hit1 and fwd_hit2, output, 1 each, a queued value supersedes the register-file value.
REQ-014 SHALL have ports fwd_data1 and fwd_data2, output, 64 each, forwarded value.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1, number of occupied entries.

Function
REQ-016 SHALL be a circular FIFO: head/tail pointers wrap modulo DEPTH; full when count==DEPTH, empty when count==0.
REQ-017 SHALL drive in_ready = (count != DEPTH), combinationally from state only (never from in_valid).
REQ-018 SHALL accept a request when in_valid && in_ready; if in_reg==31 the request SHALL be consumed (handshake completes) but not enqueued.
REQ-019 SHALL drive RegWrite = !empty && !wr_stall, with WriteRegister/WriteData equal to the head entry; when empty, WriteRegister=0 and WriteData=0.
REQ-020 SHALL pop the head on every cycle RegWrite==1; zero-latency drain, one entry per cycle max.
REQ-021 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers; when full, no push occurs even if a pop occurs that cycle.
REQ-022 SHALL preserve write order: entries reach the register file strictly in acceptance order, duplicates to the same register all written.
REQ-023 SHALL assert fwd_hitN when any occupied entry has reg == ReadRegisterN and ReadRegisterN != 31; fwd_dataN SHALL be the data of the youngest such entry, else 0.
REQ-024 SHALL include the head entry in forwarding even on the cycle it is being written; a request being accepted this cycle SHALL NOT be forwarded until the next cycle.
REQ-025 SHALL hold all state when wr_stall==1 and no push occurs.

Reset
REQ-026 SHALL, on rst asserted, immediately clear pointers and count, giving in_ready=1, RegWrite=0, WriteRegister=0, WriteData=0, fwd_hit1/2=0, fwd_data1/2=0, count=0.
REQ-027 SHALL discard all queued entries on reset mid-operation; entry payload storage needs no reset.

Structure
REQ-028 SHALL take the register-number width (5), data width (64) and zero-register index (31) from a shared package regfile_pkg, along with a wb_entry_t typedef {reg, data}.
REQ-029 SHALL implement forwarding as one sub-module wb_fwd_match, instantiated twice, scanning entries oldest-to-youngest.

Verification
REQ-030 SHALL cover: push (5, 0xAA) with wr_stall=0 -> next cycle RegWrite=1, WriteRegister=5, WriteData=0xAA, then count=0.
REQ-031 SHALL cover: wr_stall=1, push 5 requests at DEPTH=4 -> in_ready=0 after 4 accepts, count=4, 5th held; release stall -> 4 writes in order, then 5th.
REQ-032 SHALL cover: queue (3,0x1),(3,0x2), ReadRegister1=3 with stall -> fwd_hit1=1, fwd_data1=0x2.
REQ-033 SHALL cover: push (31, 0xFF) -> handshake completes, count stays 0, RegWrite never asserted; ReadRegister2=31 -> fwd_hit2=0.
REQ-034 SHALL cover: full queue, stall released while in_valid=1 -> count 4->3 next cycle, no push that cycle, push accepted following cycle.
REQ-035 SHALL cover: rst pulse asynchronously mid-drain with count=3 -> count=0, RegWrite=0 before next clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back buffer.
//   REG_W     : register number width
//   DATA_W    : register value width
//   ZERO_REG  : register index whose writes are discarded
//   wb_entry_t: one queued write-back {reg_num, data}
package regfile_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 64;

    localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [REG_W-1:0]  reg_num;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // True when the register number addresses the discard register.
    function automatic logic is_zero_reg(input logic [REG_W-1:0] r);
        return (r == ZERO_REG);
    endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// Forwarding match for one register-file read port.
// Scans the occupied entries from oldest (head) to youngest so that the
// last match seen, i.e. the youngest queued value, wins.
//   entries : FIFO payload storage
//   head    : index of the oldest occupied entry
//   count   : number of occupied entries
//   rd_reg  : snooped read address
//   hit     : a queued value supersedes the register-file value
//   data    : forwarded value (0 when no hit)
import regfile_pkg::*;

module wb_fwd_match #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wb_entry_t           entries [DEPTH],
    input  logic [PTR_W-1:0]    head,
    input  logic [CNT_W-1:0]    count,
    input  logic [REG_W-1:0]    rd_reg,
    output logic                hit,
    output logic [DATA_W-1:0]   data
);

    logic [PTR_W-1:0] slot_s;
    logic             match_s;

    // Oldest-to-youngest scan; later matches overwrite earlier ones.
    always_comb begin
        hit     = 1'b0;
        data    = {DATA_W{1'b0}};
        slot_s  = {PTR_W{1'b0}};
        match_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_s  = head + PTR_W'(i);
            match_s = (CNT_W'(i) < count)
                   && (entries[slot_s].reg_num == rd_reg)
                   && !is_zero_reg(rd_reg);
            hit  = hit | match_s;
            data = match_s ? entries[slot_s].data : data;
        end
    end

endmodule

// File: rtl/regfile_wb_buffer.sv
// Write-back buffer in front of a single register-file write port.
// Requests are queued in a circular FIFO and drained one per cycle
// whenever the write port is free; queued values are forwarded to the
// two read ports so readers never see a stale register-file value.
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_ready        : request handshake
//   in_reg/in_data           : destination register and value
//   wr_stall                 : register-file write port busy
//   RegWrite/WriteRegister/WriteData : register-file write port
//   ReadRegister1/2          : snooped read addresses
//   fwd_hit1/2, fwd_data1/2  : forwarding results
//   count                    : occupied entries
import regfile_pkg::*;

module regfile_wb_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [REG_W-1:0]            in_reg,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        wr_stall,
    output logic                        RegWrite,
    output logic [REG_W-1:0]            WriteRegister,
    output logic [DATA_W-1:0]           WriteData,
    input  logic [REG_W-1:0]            ReadRegister1,
    input  logic [REG_W-1:0]            ReadRegister2,
    output logic                        fwd_hit1,
    output logic                        fwd_hit2,
    output logic [DATA_W-1:0]           fwd_data1,
    output logic [DATA_W-1:0]           fwd_data2,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          mem_r [DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;

    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    wb_entry_t          new_entry_s;
    wb_entry_t          head_entry_s;

    assign new_entry_s.reg_num = in_reg;
    assign new_entry_s.data    = in_data;
    assign head_entry_s        = mem_r[head_r];
    assign count               = count_r;

    // Handshake, push/pop decisions and the register-file write port.
    always_comb begin
        empty_s  = (count_r == {CNT_W{1'b0}});
        in_ready = (count_r != CNT_W'(DEPTH));
        // Writes to the zero register complete the handshake but are dropped.
        push_s   = in_valid && in_ready && !is_zero_reg(in_reg);
        pop_s    = !empty_s && !wr_stall;
        RegWrite = pop_s;
        if (empty_s) begin
            WriteRegister = {REG_W{1'b0}};
            WriteData     = {DATA_W{1'b0}};
        end else begin
            WriteRegister = head_entry_s.reg_num;
            WriteData     = head_entry_s.data;
        end
    end

    // Pointer and occupancy state; reset discards every queued entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload storage; only the occupancy state needs a reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[tail_r] <= new_entry_s;
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries (mem_r),
        .head    (head_r),
        .count   (count_r),
        .rd_reg  (ReadRegister1),
        .hit     (fwd_hit1),
        .data    (fwd_data1)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries (mem_r),
        .head    (head_r),
        .count   (count_r),
        .rd_reg  (ReadRegister2),
        .hit     (fwd_hit2),
        .data    (fwd_data2)
    );

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Scoreboard bench for regfile_wb_buffer (DEPTH=4): accepted requests push
// their expected register-file write into a queue; a negedge monitor pops
// and compares whenever RegWrite is asserted.
module tb_regfile_wb_buffer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [63:0] in_data;
    logic        wr_stall;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [63:0] fwd_data1;
    logic [63:0] fwd_data2;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;

    logic [4:0]  exp_reg  [$];
    logic [63:0] exp_data [$];

    regfile_wb_buffer #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg        (in_reg),
        .in_data       (in_data),
        .wr_stall      (wr_stall),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .fwd_hit1      (fwd_hit1),
        .fwd_hit2      (fwd_hit2),
        .fwd_data1     (fwd_data1),
        .fwd_data2     (fwd_data2),
        .count         (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic do_push(input logic [4:0] r, input logic [63:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
        for (int k = 0; k < 20 && !done; k++) begin
            if (in_ready) begin
                if (r != 5'd31) begin
                    exp_reg.push_back(r);
                    exp_data.push_back(d);
                end
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: got in_ready=0 expected acceptance of reg %0d", r);
        end
    endtask

    // Scoreboard monitor: every register-file write must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && RegWrite) begin
            if (exp_reg.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got reg %0d data %0h expected no write",
                         WriteRegister, WriteData);
            end else begin
                check("wb_reg",  {59'd0, WriteRegister}, {59'd0, exp_reg.pop_front()});
                check("wb_data", WriteData, exp_data.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_reg = 5'd0; in_data = 64'd0;
        wr_stall = 1'b0; ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;

        // Reset state, checked before the first clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_regwrite", {63'd0, RegWrite}, 64'd0);
        check("rst_wreg",     {59'd0, WriteRegister}, 64'd0);
        check("rst_wdata",    WriteData, 64'd0);
        check("rst_hit1",     {63'd0, fwd_hit1}, 64'd0);
        check("rst_hit2",     {63'd0, fwd_hit2}, 64'd0);
        check("rst_fdata1",   fwd_data1, 64'd0);
        check("rst_fdata2",   fwd_data2, 64'd0);
        check("rst_count",    {61'd0, count}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single write drains the next cycle.
        do_push(5'd5, 64'hAA);
        check("single_regwrite", {63'd0, RegWrite}, 64'd1);
        check("single_wreg",     {59'd0, WriteRegister}, 64'd5);
        check("single_wdata",    WriteData, 64'hAA);
        tick();
        check("single_count0",   {61'd0, count}, 64'd0);

        // Fill under stall, fifth request held, then drain in order.
        wr_stall = 1'b1;
        do_push(5'd1, 64'h10);
        do_push(5'd2, 64'h20);
        do_push(5'd3, 64'h30);
        do_push(5'd4, 64'h40);
        check("full_count",    {61'd0, count}, 64'd4);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b1; in_reg = 5'd6; in_data = 64'h60;
        tick();
        tick();
        check("held_count", {61'd0, count}, 64'd4);
        ReadRegister1 = 5'd2; ReadRegister2 = 5'd9;
        #1;
        check("full_hit1",   {63'd0, fwd_hit1}, 64'd1);
        check("full_fdata1", fwd_data1, 64'h20);
        check("full_hit2",   {63'd0, fwd_hit2}, 64'd0);
        check("full_fdata2", fwd_data2, 64'd0);
        // Stall released while the request is still presented: pop only.
        wr_stall = 1'b0;
        tick();
        check("release_count",    {61'd0, count}, 64'd3);
        check("release_in_ready", {63'd0, in_ready}, 64'd1);
        exp_reg.push_back(5'd6);
        exp_data.push_back(64'h60);
        tick();
        in_valid = 1'b0;
        check("pushpop_count", {61'd0, count}, 64'd3);
        tick(); tick(); tick();
        check("drained_count", {61'd0, count}, 64'd0);

        // Youngest duplicate wins; accepted request not forwarded same cycle.
        wr_stall = 1'b1;
        do_push(5'd3, 64'h1);
        do_push(5'd3, 64'h2);
        ReadRegister1 = 5'd3; ReadRegister2 = 5'd3;
        #1;
        check("dup_hit1",   {63'd0, fwd_hit1}, 64'd1);
        check("dup_fdata1", fwd_data1, 64'h2);
        check("dup_fdata2", fwd_data2, 64'h2);
        ReadRegister1 = 5'd7;
        in_valid = 1'b1; in_reg = 5'd7; in_data = 64'h77;
        #1;
        check("pre_accept_hit1", {63'd0, fwd_hit1}, 64'd0);
        exp_reg.push_back(5'd7);
        exp_data.push_back(64'h77);
        tick();
        in_valid = 1'b0;
        check("post_accept_hit1",   {63'd0, fwd_hit1}, 64'd1);
        check("post_accept_fdata1", fwd_data1, 64'h77);
        wr_stall = 1'b0;
        tick();
        tick();
        // Entry 7 is the head and is being written this cycle.
        check("head_fwd_regwrite", {63'd0, RegWrite}, 64'd1);
        check("head_fwd_hit1",     {63'd0, fwd_hit1}, 64'd1);
        check("head_fwd_fdata1",   fwd_data1, 64'h77);
        tick();
        check("after_head_hit1", {63'd0, fwd_hit1}, 64'd0);

        // Zero-register request is consumed but never queued.
        ReadRegister2 = 5'd31;
        do_push(5'd31, 64'hFF);
        check("zero_count", {61'd0, count}, 64'd0);
        check("zero_hit2",  {63'd0, fwd_hit2}, 64'd0);
        tick();

        // Asynchronous reset mid-drain discards queued entries.
        wr_stall = 1'b1;
        do_push(5'd9,  64'h91);
        do_push(5'd10, 64'hA2);
        do_push(5'd11, 64'hB3);
        do_push(5'd12, 64'hC4);
        wr_stall = 1'b0;
        tick();
        check("middrain_count", {61'd0, count}, 64'd3);
        ReadRegister1 = 5'd10;
        #1 rst = 1'b1;
        #1;
        check("async_rst_count",    {61'd0, count}, 64'd0);
        check("async_rst_regwrite", {63'd0, RegWrite}, 64'd0);
        check("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("async_rst_wdata",    WriteData, 64'd0);
        check("async_rst_hit1",     {63'd0, fwd_hit1}, 64'd0);
        exp_reg.delete();
        exp_data.delete();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_count",    {61'd0, count}, 64'd0);
        check("post_rst_regwrite", {63'd0, RegWrite}, 64'd0);

        tick();
        check("scoreboard_empty", 64'(exp_reg.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
